// File: rtl/calc_core_param.sv
// calc_core_param: keypad-driven signed calculator core with saturating add/sub/mul.
// Optional feature: define CALC_MUL_EN to build the multiply operator (operator code 3).
module calc_core_param #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             read_input,
    input  logic [3:0]       keypad_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    output logic             key_read,
    output logic [WIDTH-1:0] display_output,
    output logic             complete,
    output logic             overflow
);

    typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    localparam logic [2:0] KEY_ADD = 3'd1;
    localparam logic [2:0] KEY_SUB = 3'd2;
`ifdef CALC_MUL_EN
    localparam logic [2:0] KEY_MUL = 3'd3;
`endif
    localparam logic [2:0] KEY_NEG = 3'd4;
    localparam logic [2:0] KEY_CLR = 3'd5;

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int DW = WIDTH + 5;
    localparam int PW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
    op_t                     op_q, op_d, chain_op_q, chain_op_d;
    logic                    chain_q, chain_d;
    logic [CW-1:0]           a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic                    ack_pend_q, ack_pend_d;
    logic                    key_read_q, key_read_d;
    logic                    complete_q, complete_d;
    logic                    overflow_q, overflow_d;
    logic [WIDTH-1:0]        display_q, display_d;

    logic signed [PW-1:0]    res_wide;
    logic signed [WIDTH-1:0] res_sat;
    logic                    res_ovf;

    logic signed [WIDTH-1:0] dig_base, dig_val;
    logic [CW-1:0]           dig_cnt, dig_cnt_next;
    logic signed [DW-1:0]    dig_wide;
    logic                    dig_ok;

    logic signed [WIDTH-1:0] neg_base, neg_val;
    logic                    neg_ovf;

    logic                    accept, key_arith;
    op_t                     key_op;

    // Full-precision A op B, then clamp into the signed WIDTH range.
    always_comb begin
        case (op_q)
            OP_SUB:  res_wide = PW'(a_q) - PW'(b_q);
`ifdef CALC_MUL_EN
            OP_MUL:  res_wide = PW'(a_q) * PW'(b_q);
`endif
            default: res_wide = PW'(a_q) + PW'(b_q);
        endcase
        res_sat = res_wide[WIDTH-1:0];
        res_ovf = 1'b0;
        if (res_wide > PW'(MAX_POS)) begin
            res_sat = MAX_POS;
            res_ovf = 1'b1;
        end else if (res_wide < PW'(MIN_NEG)) begin
            res_sat = MIN_NEG;
            res_ovf = 1'b1;
        end
    end

    // OP_WAIT and DONE start a fresh operand, so the digit applies to zero.
    always_comb begin
        dig_base = a_q;
        dig_cnt  = a_cnt_q;
        case (state_q)
            ENTER_B: begin
                dig_base = b_q;
                dig_cnt  = b_cnt_q;
            end
            OP_WAIT, DONE: begin
                dig_base = '0;
                dig_cnt  = '0;
            end
            default: ;
        endcase
        dig_wide = DW'(dig_base) * DW'(10) + $signed({{(DW-4){1'b0}}, keypad_input});
        dig_ok = (int'(dig_cnt) < MAX_DIGITS) &&
                 (dig_wide <= DW'(MAX_POS)) && (dig_wide >= DW'(MIN_NEG));
        dig_val      = dig_ok ? dig_wide[WIDTH-1:0] : dig_base;
        dig_cnt_next = dig_ok ? dig_cnt + CW'(1) : dig_cnt;

        neg_base = (state_q == ENTER_B) ? b_q : a_q;
        neg_ovf  = (neg_base == MIN_NEG);
        neg_val  = neg_ovf ? MAX_POS : -neg_base;
    end

    always_comb begin
        key_arith = 1'b1;
        key_op    = OP_ADD;
        case (operator_input)
            KEY_ADD: key_op = OP_ADD;
            KEY_SUB: key_op = OP_SUB;
`ifdef CALC_MUL_EN
            KEY_MUL: key_op = OP_MUL;
`endif
            default: key_arith = 1'b0;
        endcase
    end

    assign accept = read_input && !ack_pend_q && (state_q != EXEC);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        chain_d    = chain_q;
        chain_op_d = chain_op_q;
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        overflow_d = overflow_q;
        key_read_d = accept;
        ack_pend_d = (ack_pend_q && read_input) || accept;

        if (state_q == EXEC) begin
            a_d        = res_sat;
            overflow_d = overflow_q | res_ovf;
            if (chain_q) begin
                op_d    = chain_op_q;
                state_d = OP_WAIT;
            end else begin
                state_d = DONE;
            end
        end else if (accept) begin
            if (equal_input) begin
                chain_d = 1'b0;
                case (state_q)
                    ENTER_A: state_d = DONE;
                    OP_WAIT: begin
                        b_d     = '0;
                        b_cnt_d = '0;
                        state_d = EXEC;
                    end
                    default: state_d = EXEC;
                endcase
            end else if (operator_input != 3'd0) begin
                if (key_arith) begin
                    case (state_q)
                        OP_WAIT: op_d = key_op;
                        ENTER_B: begin
                            chain_d    = 1'b1;
                            chain_op_d = key_op;
                            state_d    = EXEC;
                        end
                        default: begin
                            op_d    = key_op;
                            state_d = OP_WAIT;
                        end
                    endcase
                end else if (operator_input == KEY_NEG) begin
                    if (state_q == ENTER_B) begin
                        b_d        = neg_val;
                        overflow_d = overflow_q | neg_ovf;
                    end else if (state_q != OP_WAIT) begin
                        a_d        = neg_val;
                        overflow_d = overflow_q | neg_ovf;
                    end
                end else if (operator_input == KEY_CLR) begin
                    a_d        = '0;
                    b_d        = '0;
                    a_cnt_d    = '0;
                    b_cnt_d    = '0;
                    op_d       = OP_ADD;
                    overflow_d = 1'b0;
                    state_d    = ENTER_A;
                end
            end else if (keypad_input < 4'd10) begin
                case (state_q)
                    ENTER_B, OP_WAIT: begin
                        b_d     = dig_val;
                        b_cnt_d = dig_cnt_next;
                        state_d = ENTER_B;
                    end
                    default: begin
                        if (state_q == DONE) overflow_d = 1'b0;
                        a_d     = dig_val;
                        a_cnt_d = dig_cnt_next;
                        state_d = ENTER_A;
                    end
                endcase
            end
        end

        complete_d = (state_d == DONE);
        display_d  = (state_d == ENTER_B) ? b_d : a_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= ENTER_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            chain_q    <= 1'b0;
            chain_op_q <= OP_ADD;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            ack_pend_q <= 1'b0;
            key_read_q <= 1'b0;
            complete_q <= 1'b0;
            overflow_q <= 1'b0;
            display_q  <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            chain_q    <= chain_d;
            chain_op_q <= chain_op_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            ack_pend_q <= ack_pend_d;
            key_read_q <= key_read_d;
            complete_q <= complete_d;
            overflow_q <= overflow_d;
            display_q  <= display_d;
        end
    end

    assign key_read       = key_read_q;
    assign complete       = complete_q;
    assign overflow       = overflow_q;
    assign display_output = display_q;

endmodule

// File: tb/tb_calc_core_param.sv
// Directed bench for calc_core_param (WIDTH=16, MAX_DIGITS=4); MUL scenario follows CALC_MUL_EN.
module tb_calc_core_param;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             RST;
    logic             read_input;
    logic [3:0]       keypad_input;
    logic [2:0]       operator_input;
    logic             equal_input;
    logic             key_read;
    logic [WIDTH-1:0] display_output;
    logic             complete;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int kr_count = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    calc_core_param #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
        .clk            (clk),
        .RST            (RST),
        .read_input     (read_input),
        .keypad_input   (keypad_input),
        .operator_input (operator_input),
        .equal_input    (equal_input),
        .key_read       (key_read),
        .display_output (display_output),
        .complete       (complete),
        .overflow       (overflow)
    );

    always @(negedge clk) begin
        if (key_read === 1'b1) kr_count++;
        if (complete === 1'b1) done_count++;
    end

    task automatic press(input logic eq, input logic [2:0] op, input logic [3:0] dig);
        int cyc;
        @(negedge clk);
        read_input = 1'b1; equal_input = eq; operator_input = op; keypad_input = dig;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (key_read !== 1'b1 && cyc < 20);
        checks++;
        if (key_read !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: key_read=%b after %0d cycles, required 1", key_read, cyc);
        end
        read_input = 1'b0; equal_input = 1'b0; operator_input = 3'd0; keypad_input = 4'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic dig(input logic [3:0] d);
        press(1'b0, 3'd0, d);
    endtask

    task automatic opk(input logic [2:0] o);
        press(1'b0, o, 4'hF);
    endtask

    task automatic eqk();
        press(1'b1, 3'd0, 4'hF);
    endtask

    task automatic test_reset();
        RST = 1'b1; read_input = 1'b0; equal_input = 1'b0; operator_input = 3'd0; keypad_input = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({key_read, complete, overflow, display_output} !== '0) begin
            errors++;
            $display("FAIL reset_hold: kr=%b cmp=%b ovf=%b disp=%0d, required all 0",
                     key_read, complete, overflow, display_output);
        end
        RST = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({key_read, complete, overflow, display_output} !== '0) begin
            errors++;
            $display("FAIL reset_release: kr=%b cmp=%b ovf=%b disp=%0d, required all 0",
                     key_read, complete, overflow, display_output);
        end
    endtask

    task automatic test_add();
        int kr0;
        kr0 = kr_count;
        dig(1); dig(2);
        checks++;
        if (display_output !== 16'd12) begin errors++; $display("FAIL add_a: display=%0d required 12", $signed(display_output)); end
        opk(3'd1); dig(3); dig(4);
        checks++;
        if (display_output !== 16'd34) begin errors++; $display("FAIL add_b: display=%0d required 34", $signed(display_output)); end
        eqk();
        checks++;
        if (display_output !== 16'd46) begin errors++; $display("FAIL add_result: display=%0d required 46", $signed(display_output)); end
        checks++;
        if (complete !== 1'b1) begin errors++; $display("FAIL add_complete: complete=%b required 1", complete); end
        checks++;
        if (kr_count - kr0 != 6) begin errors++; $display("FAIL add_acks: pulses=%0d required 6", kr_count - kr0); end
    endtask

    task automatic test_repeat_equals();
        opk(3'd5);
        dig(5); opk(3'd2); dig(9); eqk();
        checks++;
        if (display_output !== -16'sd4) begin errors++; $display("FAIL rep_first: display=%0d required -4", $signed(display_output)); end
        eqk();
        checks++;
        if (display_output !== -16'sd13) begin errors++; $display("FAIL rep_second: display=%0d required -13", $signed(display_output)); end
        checks++;
        if (complete !== 1'b1) begin errors++; $display("FAIL rep_complete: complete=%b required 1", complete); end
    endtask

    task automatic test_chain();
        int d0;
        opk(3'd5);
        d0 = done_count;
        dig(2); opk(3'd1); dig(3); opk(3'd2);
        checks++;
        if (display_output !== 16'd5) begin errors++; $display("FAIL chain_mid: display=%0d required 5", $signed(display_output)); end
        dig(1);
        checks++;
        if (done_count != d0) begin errors++; $display("FAIL chain_early_complete: complete cycles=%0d required 0", done_count - d0); end
        eqk();
        checks++;
        if (display_output !== 16'd4) begin errors++; $display("FAIL chain_result: display=%0d required 4", $signed(display_output)); end
        checks++;
        if (complete !== 1'b1) begin errors++; $display("FAIL chain_complete: complete=%b required 1", complete); end
    endtask

    task automatic test_held_key();
        int kr0;
        opk(3'd5);
        kr0 = kr_count;
        @(negedge clk);
        read_input = 1'b1; keypad_input = 4'd7;
        repeat (10) @(negedge clk);
        read_input = 1'b0; keypad_input = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (kr_count - kr0 != 1) begin errors++; $display("FAIL held_acks: pulses=%0d required 1", kr_count - kr0); end
        checks++;
        if (display_output !== 16'd7) begin errors++; $display("FAIL held_display: display=%0d required 7", $signed(display_output)); end
    endtask

    task automatic test_saturation();
        opk(3'd5);
        dig(9); dig(9); dig(9); dig(9); dig(9);
        checks++;
        if (display_output !== 16'd9999) begin errors++; $display("FAIL max_digits: display=%0d required 9999", $signed(display_output)); end
        opk(3'd1); dig(9); dig(9); dig(9); dig(9); eqk(); eqk();
        checks++;
        if (display_output !== 16'd29997 || overflow !== 1'b0) begin
            errors++; $display("FAIL add_29997: display=%0d ovf=%b required 29997 ovf=0", $signed(display_output), overflow);
        end
        eqk();
        checks++;
        if (display_output !== 16'd32767 || overflow !== 1'b1) begin
            errors++; $display("FAIL add_sat: display=%0d ovf=%b required 32767 ovf=1", $signed(display_output), overflow);
        end
        dig(3);
        checks++;
        if (display_output !== 16'd3 || overflow !== 1'b0 || complete !== 1'b0) begin
            errors++; $display("FAIL done_digit: display=%0d ovf=%b cmp=%b required 3 ovf=0 cmp=0",
                               $signed(display_output), overflow, complete);
        end
        opk(3'd4);
        checks++;
        if (display_output !== -16'sd3) begin errors++; $display("FAIL neg: display=%0d required -3", $signed(display_output)); end
        opk(3'd2); dig(9); dig(9); dig(9); dig(9); eqk(); eqk(); eqk(); eqk();
        checks++;
        if (display_output !== 16'h8000 || overflow !== 1'b1) begin
            errors++; $display("FAIL sub_sat: display=%0d ovf=%b required -32768 ovf=1", $signed(display_output), overflow);
        end
        opk(3'd4);
        checks++;
        if (display_output !== 16'd32767) begin errors++; $display("FAIL neg_sat: display=%0d required 32767", $signed(display_output)); end
    endtask

`ifdef CALC_MUL_EN
    task automatic test_mul();
        opk(3'd5);
        dig(9); dig(9); dig(9); dig(9); opk(3'd3); dig(9); dig(9); dig(9); dig(9); eqk();
        checks++;
        if (display_output !== 16'd32767 || overflow !== 1'b1) begin
            errors++; $display("FAIL mul_sat: display=%0d ovf=%b required 32767 ovf=1", $signed(display_output), overflow);
        end
    endtask
`else
    task automatic test_mul();
        int kr0;
        opk(3'd5);
        kr0 = kr_count;
        dig(9); dig(9); dig(9); dig(9); opk(3'd3); eqk();
        checks++;
        if (kr_count - kr0 != 6) begin errors++; $display("FAIL mul_off_acks: pulses=%0d required 6", kr_count - kr0); end
        checks++;
        if (display_output !== 16'd9999 || overflow !== 1'b0 || complete !== 1'b1) begin
            errors++; $display("FAIL mul_off: display=%0d ovf=%b cmp=%b required 9999 ovf=0 cmp=1",
                               $signed(display_output), overflow, complete);
        end
    endtask
`endif

    task automatic test_reset_exec();
        int d0;
        opk(3'd5);
        dig(8); opk(3'd1); dig(1);
        d0 = done_count;
        @(negedge clk);
        read_input = 1'b1; equal_input = 1'b1;
        @(negedge clk);
        RST = 1'b1;
        read_input = 1'b0; equal_input = 1'b0;
        #1;
        checks++;
        if ({key_read, complete, overflow, display_output} !== '0) begin
            errors++;
            $display("FAIL exec_reset: kr=%b cmp=%b ovf=%b disp=%0d, required all 0",
                     key_read, complete, overflow, display_output);
        end
        repeat (2) @(negedge clk);
        RST = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_count != d0) begin errors++; $display("FAIL exec_no_complete: complete cycles=%0d required 0", done_count - d0); end
        dig(3); opk(3'd1); dig(4); eqk();
        checks++;
        if (display_output !== 16'd7 || complete !== 1'b1) begin
            errors++; $display("FAIL after_reset_calc: display=%0d cmp=%b required 7 cmp=1", $signed(display_output), complete);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_repeat_equals();
        test_chain();
        test_held_key();
        test_saturation();
        test_mul();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_core_param.md
CALC_CORE_PARAM -- requirements
Module: calc_core_param

Interface
REQ-001 Parameter WIDTH, default 16: signed two's-complement datapath width; legal range 8..32.
REQ-002 Parameter MAX_DIGITS, default 4: maximum decimal digits per operand.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 read_input  input  1  a decoded key is present on the key fields.
REQ-006 keypad_input  input  4  digit value; 0..9 valid, 10..15 ignored.
REQ-007 operator_input  input  3  0 none, 1 ADD, 2 SUB, 3 MUL, 4 NEG, 5 CLR; 6..7 ignored.
REQ-008 equal_input  input  1  equals key.
REQ-009 key_read  output  1  one-cycle acknowledge of the consumed key.
REQ-010 display_output  output  WIDTH  value currently shown.
REQ-011 complete  output  1  result of an equals operation is valid.
REQ-012 overflow  output  1  a saturation occurred in the current calculation (sticky).

Function
REQ-013 The block SHALL accept a key when read_input=1, no acknowledge is pending, and the state is not EXEC.
REQ-014 key_read SHALL pulse high for exactly one cycle, in the cycle after acceptance.
REQ-015 After acceptance, no further key SHALL be accepted until read_input has been sampled low.
REQ-016 Decode priority within one accepted key SHALL be: equal_input, then nonzero operator_input, then digit.
REQ-017 The state machine SHALL have states ENTER_A, OP_WAIT, ENTER_B, EXEC and DONE; the reset state is ENTER_A.
REQ-018 Digit in ENTER_A or ENTER_B: operand = operand*10 + digit; the digit SHALL be dropped if MAX_DIGITS digits are already entered or the result would exceed +(2^(WIDTH-1)-1).
REQ-019 Digit in OP_WAIT: B SHALL be cleared to 0, then the digit applied as in REQ-018; next state ENTER_B.
REQ-020 Digit in DONE: A SHALL be cleared to 0, overflow cleared, complete deasserted, then the digit applied; next state ENTER_A.
REQ-021 ADD/SUB/MUL in ENTER_A or DONE: latch the pending op; A holds the current value (the prior result when in DONE); next state OP_WAIT.
REQ-022 ADD/SUB/MUL in OP_WAIT: replace the pending op only.
REQ-023 ADD/SUB/MUL in ENTER_B: go to EXEC, write A = A op B, latch the new op, then go to OP_WAIT with complete=0 (chaining).
REQ-024 NEG: negate the operand being entered (A in ENTER_A/DONE, B in ENTER_B; ignored in OP_WAIT); -(-2^(WIDTH-1)) SHALL saturate to max positive and set overflow.
REQ-025 CLR in any state except EXEC: A=B=0, pending op=ADD, overflow=0, complete=0; next state ENTER_A.
REQ-026 Equal in ENTER_A: result = A; go to DONE.
REQ-027 Equal in OP_WAIT: use B=0.
REQ-028 Equal in ENTER_B: EXEC for one cycle, then DONE.
REQ-029 Equal in DONE: repeat the last op with the last B.
REQ-030 complete SHALL be high in exactly the DONE state, starting the cycle after EXEC.
REQ-031 ADD/SUB/MUL SHALL compute at full precision and saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any saturation SHALL set overflow.
REQ-032 display_output SHALL show A in ENTER_A/OP_WAIT/DONE and B in ENTER_B, updating the cycle after the key is accepted.
REQ-033 read_input asserted during EXEC SHALL be held off (no key_read) and accepted the cycle after EXEC.

Reset
REQ-034 On RST=1, asynchronously: state=ENTER_A, A=B=0, pending op=ADD, digit counters=0, key_read=0, complete=0, overflow=0, display_output=0, acknowledge-pending=0.
REQ-035 Reset asserted mid-EXEC SHALL discard the computation with no complete pulse.

Configuration
REQ-036 Macro CALC_MUL_EN: when defined, MUL (operator 3) is implemented per REQ-021..REQ-023 and REQ-031.
REQ-037 When CALC_MUL_EN is undefined, no multiplier SHALL be synthesised; operator 3 SHALL be acknowledged and otherwise ignored.

Verification
REQ-038 Keys 1,2,ADD,3,4,= -> key_read one pulse per key; display 12 then 34; complete=1; display_output=46.
REQ-039 Keys 5,SUB,9,=,= -> display -4, then -13 after the second equals.
REQ-040 WIDTH=16, CALC_MUL_EN: keys 9,9,9,9,MUL,9,9,9,9,= -> display_output=32767, overflow=1.
REQ-041 Keys 2,ADD,3,SUB,1,= -> display shows 5 after SUB; final display 4; complete low until equals.
REQ-042 read_input held high for 10 cycles on digit 7 -> exactly one key_read pulse; display 7.
REQ-043 RST pulsed during EXEC after 8,ADD,1,= -> all outputs 0, state ENTER_A, no complete pulse.
